// File: rtl/ecs8_pkg.sv
// Shared timing constants and helpers for the ECS8 board-input logic.
package ecs8_pkg;

  localparam int SYS_CLK_HZ       = 85196800;
  localparam int DEBOUNCE_TICK_US = 100;

  // Cycles per debounce tick, rounded to nearest: 85196.8 kHz * 100 us -> 8520.
  localparam int DEF_PRESCALE = (SYS_CLK_HZ / 1000 * DEBOUNCE_TICK_US + 500) / 1000;
  localparam int DEF_DEBOUNCE = 100;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchroniser, tick-driven stability counter,
// stable level register and registered rise/fall pulses.
module debounce_bit
  import ecs8_pkg::*;
#(
  parameter int   DEBOUNCE = 3,
  parameter logic RST_BIT  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic stb,
  output logic rise,
  output logic fall
);

  localparam int                CNT_W    = clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Stage boundary: asynchronous pin into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= RST_BIT;
      s2 <= RST_BIT;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Stage boundary: stability filter; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      stb  <= RST_BIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == stb) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          cnt  <= '0;
          stb  <= s2;
          rise <= s2;
          fall <= ~s2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/input_debounce.sv
// Debounce/edge-detect front end for the PIO inputs: shared prescaler,
// per-bit filters, sticky maskable change events and a single irq line.
module input_debounce
  import ecs8_pkg::*;
#(
  parameter int          DW       = 4,
  parameter int          PRESCALE = DEF_PRESCALE,
  parameter int          DEBOUNCE = DEF_DEBOUNCE,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_raw,
  output logic [DW-1:0] in_stb,
  output logic [DW-1:0] rise,
  output logic [DW-1:0] fall,
  input  logic [DW-1:0] evt_mask,
  input  logic [DW-1:0] evt_clr,
  output logic [DW-1:0] evt,
  output logic          irq
);

  // A one-bit counter is kept even for PRESCALE=1 so the compare stays legal.
  localparam int                 PCNT_W    = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

  logic [PCNT_W-1:0] pcnt;
  logic              tick;

  assign tick = (pcnt == PCNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PCNT_W'(1);
    end
  end

  for (genvar i = 0; i < DW; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE (DEBOUNCE),
      .RST_BIT  (RST_VAL[i])
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .raw  (in_raw[i]),
      .stb  (in_stb[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // Stage boundary: sticky events (a new edge beats a clear), then irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt <= '0;
      irq <= 1'b0;
    end else begin
      evt <= (evt & ~evt_clr) | rise | fall;
      irq <= |(evt & evt_mask);
    end
  end

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: a (PRESCALE=4, DEBOUNCE=3) instance and a
// (PRESCALE=1, DEBOUNCE=1) instance share stimulus and are checked every cycle.
module tb_input_debounce;

  localparam int DW = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_raw;
  logic [DW-1:0] evt_mask;
  logic [DW-1:0] evt_clr;

  logic [DW-1:0] stb_a, rise_a, fall_a, evt_a;
  logic          irq_a;
  logic [DW-1:0] stb_b, rise_b, fall_b, evt_b;
  logic          irq_b;

  int checks = 0;
  int errors = 0;

  input_debounce #(.DW(DW), .PRESCALE(4), .DEBOUNCE(3), .RST_VAL(4'h0)) dut_a (
    .clk(clk), .rst(rst), .in_raw(in_raw), .in_stb(stb_a), .rise(rise_a),
    .fall(fall_a), .evt_mask(evt_mask), .evt_clr(evt_clr), .evt(evt_a), .irq(irq_a)
  );

  input_debounce #(.DW(DW), .PRESCALE(1), .DEBOUNCE(1), .RST_VAL(4'h0)) dut_b (
    .clk(clk), .rst(rst), .in_raw(in_raw), .in_stb(stb_b), .rise(rise_b),
    .fall(fall_b), .evt_mask(evt_mask), .evt_clr(evt_clr), .evt(evt_b), .irq(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: edge n after reset is a tick when n mod P == P-1; the
  // synchronised value at edge n is in_raw sampled at edge n-2; a level is
  // accepted on the D-th tick inside an unbroken run of disagreement.
  int            mp [2] = '{4, 1};
  int            md [2] = '{3, 1};
  int            m_n [2];
  logic [DW-1:0] m_h1 [2], m_h2 [2];
  logic [DW-1:0] m_stb [2], m_rise [2], m_fall [2], m_evt [2];
  logic          m_irq [2];
  bit            m_inrun [2][DW];
  int            m_start [2][DW];

  task automatic model_edge();
    logic [DW-1:0] s2, nr, nf;
    bit            tk;
    int            ticks;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_n[k] = 0; m_h1[k] = '0; m_h2[k] = '0; m_stb[k] = '0;
        m_rise[k] = '0; m_fall[k] = '0; m_evt[k] = '0; m_irq[k] = 1'b0;
        for (int b = 0; b < DW; b++) m_inrun[k][b] = 1'b0;
      end else begin
        s2 = m_h2[k];
        tk = ((m_n[k] % mp[k]) == mp[k] - 1);
        m_irq[k] = |(m_evt[k] & evt_mask);
        m_evt[k] = (m_evt[k] & ~evt_clr) | m_rise[k] | m_fall[k];
        nr = '0; nf = '0;
        for (int b = 0; b < DW; b++) begin
          if (s2[b] == m_stb[k][b]) begin
            m_inrun[k][b] = 1'b0;
          end else begin
            if (!m_inrun[k][b]) begin
              m_inrun[k][b] = 1'b1;
              m_start[k][b] = m_n[k];
            end
            ticks = (m_n[k] + 1) / mp[k] - m_start[k][b] / mp[k];
            if (tk && ticks == md[k]) begin
              m_stb[k][b] = s2[b];
              nr[b] = s2[b];
              nf[b] = ~s2[b];
              m_inrun[k][b] = 1'b0;
            end
          end
        end
        m_rise[k] = nr; m_fall[k] = nf;
        m_h2[k] = m_h1[k]; m_h1[k] = in_raw;
        m_n[k] = m_n[k] + 1;
      end
    end
  endtask

  task automatic check(input string name, input int inst, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %h expected %h", name, inst, $time, act, exp);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic lit_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d..%0d", name, $time, act, lo, hi);
    end
  endtask

  task automatic compare_all();
    check("in_stb", 0, stb_a,  m_stb[0]);
    check("rise",   0, rise_a, m_rise[0]);
    check("fall",   0, fall_a, m_fall[0]);
    check("evt",    0, evt_a,  m_evt[0]);
    check("irq",    0, {3'b0, irq_a}, {3'b0, m_irq[0]});
    check("in_stb", 1, stb_b,  m_stb[1]);
    check("rise",   1, rise_b, m_rise[1]);
    check("fall",   1, fall_b, m_fall[1]);
    check("evt",    1, evt_b,  m_evt[1]);
    check("irq",    1, {3'b0, irq_b}, {3'b0, m_irq[1]});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_a, first_b, nr, nf, found;
    bit moved;

    rst = 1'b1; in_raw = 4'hF; evt_mask = 4'h0; evt_clr = 4'h0;
    steps(3);
    lit("reset_in_stb", stb_a, 0);
    lit("reset_evt", evt_a, 0);
    lit("reset_irq", irq_a, 0);

    // Leaving reset with all inputs high: filtered normally, one rise each.
    rst = 1'b0;
    first_a = -1; first_b = -1; nr = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (first_a < 0 && stb_a == 4'hF) first_a = k;
      if (first_b < 0 && stb_b == 4'hF) first_b = k;
      if (rise_a == 4'hF) nr++;
    end
    lit("release_latency_a", first_a, 12);
    lit("release_latency_b", first_b, 3);
    lit("release_rise_pulses", nr, 1);
    evt_clr = 4'hF; step(); evt_clr = 4'h0; step();

    // Clean step on bit0.
    in_raw = 4'hE; steps(20);
    in_raw = 4'hF;
    first_a = -1; nr = 0; nf = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (first_a < 0 && stb_a[0]) first_a = k;
      if (rise_a[0]) nr++;
      if (fall_a[0]) nf++;
    end
    lit_range("clean_latency", first_a, 11, 14);
    lit("clean_rise_pulses", nr, 1);
    lit("clean_fall_pulses", nf, 0);

    // Bounce on bit1: 5-cycle toggles never accumulate three ticks.
    in_raw = 4'hD; steps(20);
    moved = 1'b0;
    for (int seg = 0; seg < 8; seg++) begin
      in_raw[1] = (seg % 2 == 0);
      for (int k = 0; k < 5; k++) begin
        step();
        if (stb_a[1]) moved = 1'b1;
      end
    end
    lit("bounce_no_change", moved, 0);
    in_raw = 4'hF;
    first_a = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (first_a < 0 && stb_a[1]) first_a = k;
    end
    lit_range("bounce_hold_latency", first_a, 11, 14);

    // Events and irq on bit2.
    evt_clr = 4'hF; step(); evt_clr = 4'h0; step();
    evt_mask = 4'b0100;
    in_raw = 4'hB;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step();
      if (fall_a[2]) found = 1;
    end
    lit("evt_fall2_seen", found, 1);
    step();
    lit("evt2_set", evt_a[2], 1);
    lit("irq_lags_evt", irq_a, 0);
    step();
    lit("irq_set", irq_a, 1);
    evt_clr = 4'b0100; step(); evt_clr = 4'h0;
    lit("evt2_cleared", evt_a[2], 0);
    lit("irq_still_set", irq_a, 1);
    step();
    lit("irq_cleared", irq_a, 0);

    // Set wins over simultaneous clear on bit3.
    evt_mask = 4'h0;
    evt_clr = 4'hF; step(); evt_clr = 4'h0; step();
    in_raw = 4'h3;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step();
      if (fall_a[3]) found = 1;
    end
    lit("fall3_seen", found, 1);
    evt_clr = 4'b1000; step(); evt_clr = 4'h0;
    lit("set_beats_clear", evt_a[3], 1);
    steps(20);

    // Reset in the middle of a count on bit0 (stable 1 -> raw 0).
    in_raw = 4'h2; steps(8);
    rst = 1'b1; in_raw = 4'h0; steps(2);
    lit("midreset_in_stb", stb_a, 0);
    lit("midreset_rise", rise_a, 0);
    lit("midreset_fall", fall_a, 0);
    rst = 1'b0;
    nr = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (rise_a != 4'h0 || fall_a != 4'h0) nr++;
    end
    lit("post_reset_no_pulse", nr, 0);
    lit("post_reset_in_stb", stb_a, 0);

    // Minimal parameters: accepted on the third edge after the change.
    in_raw = 4'h1;
    first_b = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (first_b < 0 && stb_b[0]) first_b = k;
    end
    lit("edge_param_latency", first_b, 3);
    lit("edge_param_main_accepted", stb_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
